trojan_resp_checker: RTL and testbench

- Hardware stimulus and response analyser for small trojan-benchmark DUTs (N_IN-bit input, single-bit output).
- Sweeps all 2^N_IN input patterns in ascending order and drives them to the DUT.
- Samples the DUT output after each pattern and compares it to a golden truth table.
- Reports pass/fail, mismatch count and first failing pattern, so benchmark screening runs on-chip or in emulation without file logging.

---
 rtl/trojan_resp_checker_pkg.sv | 26 ++
 rtl/trojan_resp_checker_misr16.sv | 27 ++
 rtl/trojan_resp_checker.sv | 136 +++++++++++++
 tb/tb_trojan_resp_checker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/trojan_resp_checker_pkg.sv
// Shared definitions for the trojan response checker:
// FSM state encoding, MISR polynomial/seed and a popcount helper.
package trojan_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // x^16 + x^12 + x^5 + 1 (the x^16 term is implicit in the shift-out)
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // Number of set bits in a truth table of up to 2^8 entries
    function automatic int unsigned popcount(input logic [255:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 256; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/trojan_resp_checker_misr16.sv
// 16-bit multiple-input signature register used to compact DUT responses.
// Only instantiated when TROJAN_RESP_SIG_EN is defined.
module trojan_misr16
    import trojan_chk_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        din,
    output logic [15:0] sig
);

    // Seed on clear, otherwise shift left with polynomial feedback and fold in din
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= {sig[14:0], 1'b0}
                 ^ (sig[15] ? MISR_POLY : 16'h0000)
                 ^ {15'h0000, din};
        end
    end

endmodule

// File: rtl/trojan_resp_checker.sv
// Stimulus sweeper and response checker for small single-output trojan
// benchmark DUTs. Drives all 2^N_IN patterns in ascending order, compares the
// sampled response to GOLDEN and reports pass, mismatch count and first
// failing pattern. Optional response signature: define TROJAN_RESP_SIG_EN.
module trojan_resp_checker
    import trojan_chk_pkg::*;
#(
    parameter int unsigned            N_IN   = 4,
    parameter int unsigned            SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0]   GOLDEN = '0
) (
    input  logic            CK,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] pat_out,
    output logic            pat_valid,
    input  logic            dut_resp,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mism_cnt,
    output logic [N_IN-1:0] first_fail_pat,
    output logic            first_fail_vld,
    output logic [15:0]     sig
);

    localparam int unsigned     NPAT        = 1 << N_IN;
    localparam int unsigned     SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_PAT    = N_IN'(NPAT - 1);
    localparam logic [N_IN-1:0] PAT_ONE     = N_IN'(1);
    localparam logic [N_IN:0]   MISM_MAX    = (N_IN + 1)'(NPAT);
    localparam logic [N_IN:0]   MISM_ONE    = (N_IN + 1)'(1);
    localparam logic [SW-1:0]   SETTLE_INIT = SW'(SETTLE - 1);
    localparam logic [SW-1:0]   SETTLE_ONE  = SW'(1);

    state_t          state;
    logic [SW-1:0]   settle_cnt;
    logic            mismatch;
    logic [N_IN:0]   mism_next;

    // Response compare and saturating mismatch increment for the SAMPLE cycle
    always_comb begin
        mismatch  = (dut_resp != GOLDEN[pat_out]);
        mism_next = mism_cnt;
        if (mismatch && (mism_cnt != MISM_MAX)) begin
            mism_next = mism_cnt + MISM_ONE;
        end
    end

    // Sweep FSM; done/pass/pat_valid are updated on entry to DONE so that
    // they are visible during the single DONE cycle
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            pat_out        <= '0;
            pat_valid      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mism_cnt       <= '0;
            first_fail_pat <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= HOLD;
                        busy           <= 1'b1;
                        pat_out        <= '0;
                        pat_valid      <= 1'b1;
                        pass           <= 1'b0;
                        mism_cnt       <= '0;
                        first_fail_pat <= '0;
                        first_fail_vld <= 1'b0;
                        settle_cnt     <= SETTLE_INIT;
                    end
                end
                HOLD: begin
                    if (settle_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - SETTLE_ONE;
                    end
                end
                SAMPLE: begin
                    mism_cnt <= mism_next;
                    if (mismatch && !first_fail_vld) begin
                        first_fail_pat <= pat_out;
                        first_fail_vld <= 1'b1;
                    end
                    if (pat_out == LAST_PAT) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        pass      <= (mism_next == '0);
                        pat_valid <= 1'b0;
                        pat_out   <= '0;
                    end else begin
                        state      <= HOLD;
                        pat_out    <= pat_out + PAT_ONE;
                        settle_cnt <= SETTLE_INIT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TROJAN_RESP_SIG_EN
    logic misr_en;
    logic misr_clr;

    assign misr_en  = (state == SAMPLE);
    assign misr_clr = (state == IDLE) && start;

    trojan_misr16 u_misr (
        .clk   (CK),
        .rst_n (reset),
        .en    (misr_en),
        .clr   (misr_clr),
        .din   (dut_resp),
        .sig   (sig)
    );
`else
    assign sig = 16'h0000;
`endif

endmodule

// File: tb/tb_trojan_resp_checker.sv
// Directed bench for trojan_resp_checker: table of DUT behaviours for a
// 4-input / SETTLE=1 checker plus hand-written reset, protocol and
// 3-input / SETTLE=3 sequences.
module tb_trojan_resp_checker;

    typedef struct {
        string       name;
        logic        force_en;
        logic        force_val;
        logic [15:0] flip;
        logic [4:0]  mism;
        logic [3:0]  ffp;
        logic        ffv;
        logic        pass;
        bit          hold_start;
    } vec_t;

    logic        CK = 1'b0;
    logic        reset;
    logic        start_a, start_b;

    logic [3:0]  pat_a;
    logic        pv_a, resp_a, busy_a, done_a, pass_a, ffv_a;
    logic [4:0]  mism_a;
    logic [3:0]  ffp_a;
    logic [15:0] sig_a;

    logic [2:0]  pat_b;
    logic        pv_b, resp_b, busy_b, done_b, pass_b, ffv_b;
    logic [3:0]  mism_b;
    logic [2:0]  ffp_b;
    logic [15:0] sig_b;

    logic [15:0] golden_a;
    logic        force_en, force_val;
    logic [15:0] flip;

    int passed = 0;
    int total  = 0;

    always #5 CK = ~CK;

    // DUT model: golden table with optional per-pattern flips, or stuck-at
    assign resp_a = force_en ? force_val : (golden_a[pat_a] ^ flip[pat_a]);
    assign resp_b = 1'b0;

    trojan_resp_checker #(.N_IN(4), .SETTLE(1), .GOLDEN(16'hA5C3)) u_dut_a (
        .CK(CK), .reset(reset), .start(start_a),
        .pat_out(pat_a), .pat_valid(pv_a), .dut_resp(resp_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .mism_cnt(mism_a), .first_fail_pat(ffp_a), .first_fail_vld(ffv_a),
        .sig(sig_a)
    );

    trojan_resp_checker #(.N_IN(3), .SETTLE(3), .GOLDEN(8'h5A)) u_dut_b (
        .CK(CK), .reset(reset), .start(start_b),
        .pat_out(pat_b), .pat_valid(pv_b), .dut_resp(resp_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .mism_cnt(mism_b), .first_fail_pat(ffp_b), .first_fail_vld(ffv_b),
        .sig(sig_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference MISR written bit-wise: shift in response, then apply taps 0/5/12
    function automatic logic [15:0] ref_misr(input logic [15:0] resp);
        logic [15:0] s;
        logic        fb;
        s = 16'hFFFF;
        for (int p = 0; p < 16; p++) begin
            fb = s[15];
            s  = {s[14:0], resp[p]};
            if (fb) begin
                s[0]  = ~s[0];
                s[5]  = ~s[5];
                s[12] = ~s[12];
            end
        end
        return s;
    endfunction

    function automatic logic [15:0] resp_vector();
        logic [15:0] r;
        for (int p = 0; p < 16; p++) r[p] = force_en ? force_val : (golden_a[p] ^ flip[p]);
        return r;
    endfunction

    // One sweep on instance A, starting from a negedge; cycle k is observed
    // at the negedge following edge t+k-1, so done is expected at k=33
    task automatic sweep_a(input bit hold_start, output int done_cyc, output int pulses,
                           output bit seq_ok, output logic busy_late);
        start_a = 1'b1;
        @(posedge CK);
        done_cyc = 0;
        pulses   = 0;
        seq_ok   = 1'b1;
        busy_late = 1'bx;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CK);
            if (!hold_start) start_a = 1'b0;
            if (done_cyc != 0 && k == done_cyc + 1) start_a = 1'b0;
            if (done_a === 1'b1) begin
                pulses++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (k <= 32 && (pat_a !== 4'((k - 1) / 2) || pv_a !== 1'b1)) seq_ok = 1'b0;
            if (k == 45) busy_late = busy_a;
        end
        start_a = 1'b0;
    endtask

    vec_t        vecs[6];
    int          done_cyc, pulses;
    bit          seq_ok;
    logic        busy_late;
    logic [15:0] sig_pass;
    bit          found;

    initial begin
        vecs[0] = '{"golden",    1'b0, 1'b0, 16'h0000, 5'd0, 4'd0,  1'b0, 1'b1, 1'b0};
        vecs[1] = '{"stuck0",    1'b1, 1'b0, 16'h0000, 5'd8, 4'd0,  1'b1, 1'b0, 1'b0};
        vecs[2] = '{"trojan11",  1'b0, 1'b0, 16'h0800, 5'd1, 4'd11, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{"stuck1",    1'b1, 1'b1, 16'h0000, 5'd8, 4'd2,  1'b1, 1'b0, 1'b0};
        vecs[4] = '{"flip0_15",  1'b0, 1'b0, 16'h8001, 5'd2, 4'd0,  1'b1, 1'b0, 1'b0};
        vecs[5] = '{"start_held",1'b0, 1'b0, 16'h0000, 5'd0, 4'd0,  1'b0, 1'b1, 1'b1};

        golden_a  = 16'hA5C3;
        force_en  = 1'b0;
        force_val = 1'b0;
        flip      = 16'h0000;
        start_a   = 1'b0;
        start_b   = 1'b0;
        reset     = 1'b0;
        sig_pass  = 16'h0000;

        repeat (3) @(negedge CK);
        check("reset_outputs_a", 32'({pat_a, pv_a, busy_a, done_a, pass_a, mism_a, ffp_a, ffv_a, sig_a}), 32'h0);
        check("reset_outputs_b", 32'({pat_b, pv_b, busy_b, done_b, pass_b, mism_b, ffp_b, ffv_b}), 32'h0);
        reset = 1'b1;
        @(negedge CK);

        for (int v = 0; v < 6; v++) begin
            force_en  = vecs[v].force_en;
            force_val = vecs[v].force_val;
            flip      = vecs[v].flip;
            sweep_a(vecs[v].hold_start, done_cyc, pulses, seq_ok, busy_late);
            check({vecs[v].name, "_done_cycle"}, 32'(done_cyc), 32'd33);
            check({vecs[v].name, "_done_pulses"}, 32'(pulses), 32'd1);
            check({vecs[v].name, "_pat_seq"}, 32'(seq_ok), 32'd1);
            check({vecs[v].name, "_idle_after"}, 32'({busy_late, pv_a, pat_a}), 32'h0);
            check({vecs[v].name, "_mism_cnt"}, 32'(mism_a), 32'(vecs[v].mism));
            check({vecs[v].name, "_first_fail_pat"}, 32'(ffp_a), 32'(vecs[v].ffp));
            check({vecs[v].name, "_first_fail_vld"}, 32'(ffv_a), 32'(vecs[v].ffv));
            check({vecs[v].name, "_pass"}, 32'(pass_a), 32'(vecs[v].pass));
`ifdef TROJAN_RESP_SIG_EN
            check({vecs[v].name, "_sig"}, 32'(sig_a), 32'(ref_misr(resp_vector())));
            if (v == 0) sig_pass = sig_a;
            if (v == 2) check("sig_one_bit_change", 32'(sig_a != sig_pass), 32'd1);
`else
            check({vecs[v].name, "_sig"}, 32'(sig_a), 32'h0);
`endif
        end

        // Reset mid-sweep at pattern 6, then a full fresh sweep
        force_en  = 1'b1;
        force_val = 1'b0;
        flip      = 16'h0000;
        start_a   = 1'b1;
        @(negedge CK);
        start_a = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (pat_a === 4'd6) found = 1'b1;
            else @(negedge CK);
        end
        check("reached_pat6", 32'(found), 32'd1);
        check("busy_before_reset", 32'(busy_a), 32'd1);
        reset = 1'b0;
        #1;
        check("async_reset_clears", 32'({pat_a, pv_a, busy_a, done_a, pass_a, mism_a, ffp_a, ffv_a, sig_a}), 32'h0);
        @(negedge CK);
        reset = 1'b1;
        @(negedge CK);
        sweep_a(1'b0, done_cyc, pulses, seq_ok, busy_late);
        check("post_reset_done_cycle", 32'(done_cyc), 32'd33);
        check("post_reset_pat_seq", 32'(seq_ok), 32'd1);
        check("post_reset_mism_cnt", 32'(mism_a), 32'(trojan_chk_pkg::popcount({240'h0, golden_a})));
        check("post_reset_first_fail", 32'({ffv_a, ffp_a}), 32'h10);
        check("post_reset_pass", 32'(pass_a), 32'd0);

        // Instance B: N_IN=3, SETTLE=3, stuck-at-0 response against 8'h5A
        start_b = 1'b1;
        @(posedge CK);
        done_cyc = 0;
        pulses   = 0;
        seq_ok   = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CK);
            start_b = 1'b0;
            if (done_b === 1'b1) begin
                pulses++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (k <= 32 && (pat_b !== 3'((k - 1) / 4) || pv_b !== 1'b1)) seq_ok = 1'b0;
        end
        check("b_done_cycle", 32'(done_cyc), 32'd33);
        check("b_done_pulses", 32'(pulses), 32'd1);
        check("b_pat_seq", 32'(seq_ok), 32'd1);
        check("b_mism_cnt", 32'(mism_b), 32'd4);
        check("b_first_fail", 32'({ffv_b, ffp_b}), 32'h9);
        check("b_pass_busy", 32'({pass_b, busy_b, pv_b}), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
